// File: rtl/nibble_bus_mem_bridge_pkg.sv
// Shared bus layout for the CPU nibble bus: bit positions, default widths
// and the nibble phase encoding used by the bridge.
package nibble_bus_mem_bridge_pkg;

   localparam int unsigned STROBE = 7;
   localparam int unsigned WE_N   = 5;
   localparam int unsigned DS_N   = 4;
   localparam int unsigned NIB_LO = 0;
   localparam int unsigned NIB_W  = 4;

   localparam int unsigned BUS_ADDR_W = 7;
   localparam int unsigned BUS_DW     = 8;

   typedef enum logic {
      PH_HI = 1'b0,
      PH_LO = 1'b1
   } phase_e;

endpackage

// File: rtl/nibble_bus_mem_bridge_write_assembler.sv
// Builds a full memory word from two nibble write cycles (low first, then
// high) and issues a single-cycle registered write on the high nibble.
module nibble_write_assembler
   import nibble_bus_mem_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = BUS_ADDR_W,
   parameter int unsigned DW     = BUS_DW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_strobe,
   input  logic              i_wr,
   input  phase_e            i_phase,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [NIB_W-1:0]  i_nibble,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [DW-1:0]     o_wdata,
   output logic              o_err
);

   logic [NIB_W-1:0]  r_tmp;
   logic              r_lo_valid;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DW-1:0]     r_wdata;
   logic              r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmp      <= '0;
         r_lo_valid <= 1'b0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_we <= 1'b0;
         // A strobe only invalidates the pending low nibble; tmp itself survives.
         if (i_strobe) begin
            r_lo_valid <= 1'b0;
         end else if (i_wr) begin
            if (i_phase == PH_LO) begin
               r_tmp      <= i_nibble;
               r_lo_valid <= 1'b1;
            end else begin
               r_we       <= 1'b1;
               r_waddr    <= i_addr;
               r_wdata    <= {i_nibble, r_tmp};
               r_lo_valid <= 1'b0;
               if (!r_lo_valid) r_err <= 1'b1;
            end
         end
      end
   end

   assign o_we    = r_we;
   assign o_waddr = r_waddr;
   assign o_wdata = r_wdata;
   assign o_err   = r_err;

endmodule

// File: rtl/nibble_bus_mem_bridge.sv
// Bridge between an 8-bit CPU bus and a word memory: address latch, nibble
// phase toggle and read nibble mux; write assembly lives in the sub-module.
module nibble_bus_mem_bridge
   import nibble_bus_mem_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = BUS_ADDR_W,
   parameter int unsigned DW     = BUS_DW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        bus_out,
   output logic [NIB_W-1:0]  bus_nibble,
   output logic              choose,
   output logic              data_write_n,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DW-1:0]     mem_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DW-1:0]     mem_wdata,
   output logic              err
);

   logic [ADDR_W-1:0] r_addr;
   phase_e            r_choose;
   logic              w_strobe;
   logic              w_wr;

   assign w_strobe = bus_out[STROBE];
   assign w_wr     = ~w_strobe & ~bus_out[WE_N];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr   <= '0;
         r_choose <= PH_HI;
      end else if (w_strobe) begin
         r_addr   <= bus_out[ADDR_W-1:0];
         r_choose <= PH_HI;
      end else begin
         r_choose <= (r_choose == PH_HI) ? PH_LO : PH_HI;
      end
   end

   // Address is transparent during the strobe so reads see it with no latency.
   assign mem_raddr    = w_strobe ? bus_out[ADDR_W-1:0] : r_addr;
   assign choose       = r_choose;
   assign bus_nibble   = (r_choose == PH_HI) ? mem_rdata[2*NIB_W-1:NIB_W]
                                             : mem_rdata[NIB_W-1:0];
   assign data_write_n = w_strobe ? 1'b1 : bus_out[DS_N];

   nibble_write_assembler #(
      .ADDR_W (ADDR_W),
      .DW     (DW)
   ) u_wasm (
      .clk      (clk),
      .rst_n    (rst),
      .i_strobe (w_strobe),
      .i_wr     (w_wr),
      .i_phase  (r_choose),
      .i_addr   (r_addr),
      .i_nibble (bus_out[NIB_LO +: NIB_W]),
      .o_we     (mem_we),
      .o_waddr  (mem_waddr),
      .o_wdata  (mem_wdata),
      .o_err    (err)
   );

endmodule

// File: tb/tb_nibble_bus_mem_bridge.sv
// Directed bench for the nibble bus bridge: reset, phase, read mux, writes,
// partial-write error, reset mid-write and the CPU countdown program.
module tb_nibble_bus_mem_bridge;

   logic       clk;
   logic       rst;
   logic [7:0] bus_out;
   logic [3:0] bus_nibble;
   logic       choose;
   logic       data_write_n;
   logic [6:0] mem_raddr;
   logic [7:0] mem_rdata;
   logic       mem_we;
   logic [6:0] mem_waddr;
   logic [7:0] mem_wdata;
   logic       err;

   int n_vec;
   int n_err;

   nibble_bus_mem_bridge #(
      .ADDR_W (7),
      .DW     (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus_out      (bus_out),
      .bus_nibble   (bus_nibble),
      .choose       (choose),
      .data_write_n (data_write_n),
      .mem_raddr    (mem_raddr),
      .mem_rdata    (mem_rdata),
      .mem_we       (mem_we),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [7:0] IDLE = 8'h30;

   // Advance one rising edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #1 rst = 1'b0;
      bus_out = IDLE;
      step();
      step();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus_out = IDLE;
      mem_rdata = 8'h00;
      step();
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we got=%h exp=0", mem_we); end
      n_vec++; if (mem_waddr !== 7'h00) begin n_err++; $display("FAIL rst_waddr got=%h exp=00", mem_waddr); end
      n_vec++; if (mem_wdata !== 8'h00) begin n_err++; $display("FAIL rst_wdata got=%h exp=00", mem_wdata); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%h exp=0", err); end
      n_vec++; if (choose !== 1'b0) begin n_err++; $display("FAIL rst_choose got=%h exp=0", choose); end
      n_vec++; if (mem_raddr !== 7'h00) begin n_err++; $display("FAIL rst_raddr got=%h exp=00", mem_raddr); end
      rst = 1'b1;
      #1;
   endtask

   task automatic test_strobe_phase();
      logic [3:0] exp_ch;
      exp_ch = 4'b1010;
      bus_out = 8'h85;
      #1;
      n_vec++; if (mem_raddr !== 7'h05) begin n_err++; $display("FAIL strobe_raddr_transparent got=%h exp=05", mem_raddr); end
      n_vec++; if (data_write_n !== 1'b1) begin n_err++; $display("FAIL strobe_dwn got=%h exp=1", data_write_n); end
      step();
      bus_out = IDLE;
      #1;
      n_vec++; if (mem_raddr !== 7'h05) begin n_err++; $display("FAIL latched_raddr got=%h exp=05", mem_raddr); end
      n_vec++; if (choose !== exp_ch[0]) begin n_err++; $display("FAIL choose_seq0 got=%h exp=%h", choose, exp_ch[0]); end
      for (int i = 1; i < 4; i++) begin
         step();
         n_vec++; if (choose !== exp_ch[i]) begin n_err++; $display("FAIL choose_seq%0d got=%h exp=%h", i, choose, exp_ch[i]); end
      end
   endtask

   task automatic test_read_mux();
      logic [15:0] exp_n;
      exp_n = 16'h7A7A;
      mem_rdata = 8'hA7;
      bus_out = 8'h90;
      step();
      bus_out = IDLE;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_vec++; if (bus_nibble !== exp_n[4*i +: 4]) begin n_err++; $display("FAIL read_nib%0d got=%h exp=%h", i, bus_nibble, exp_n[4*i +: 4]); end
         step();
      end
   endtask

   task automatic test_write();
      bus_out = 8'hF7;
      step();
      bus_out = IDLE;
      step();
      bus_out = 8'h02;
      #1;
      n_vec++; if (data_write_n !== 1'b0) begin n_err++; $display("FAIL wr_dwn got=%h exp=0", data_write_n); end
      step();
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL wr_lo_no_we got=%h exp=0", mem_we); end
      bus_out = 8'h0F;
      step();
      n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL wr_we got=%h exp=1", mem_we); end
      n_vec++; if (mem_waddr !== 7'h77) begin n_err++; $display("FAIL wr_waddr got=%h exp=77", mem_waddr); end
      n_vec++; if (mem_wdata !== 8'hF2) begin n_err++; $display("FAIL wr_wdata got=%h exp=F2", mem_wdata); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL wr_err got=%h exp=0", err); end
      bus_out = IDLE;
      step();
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL wr_pulse_len got=%h exp=0", mem_we); end
   endtask

   // tmp=2 is left over from test_write and must survive the strobe.
   task automatic test_partial_write();
      bus_out = 8'h85;
      step();
      bus_out = 8'h03;
      step();
      n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL part_we got=%h exp=1", mem_we); end
      n_vec++; if (mem_waddr !== 7'h05) begin n_err++; $display("FAIL part_waddr got=%h exp=05", mem_waddr); end
      n_vec++; if (mem_wdata !== 8'h32) begin n_err++; $display("FAIL part_wdata got=%h exp=32", mem_wdata); end
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL part_err got=%h exp=1", err); end
      bus_out = 8'h04;
      step();
      bus_out = 8'h05;
      step();
      n_vec++; if (mem_wdata !== 8'h54) begin n_err++; $display("FAIL part_next_wdata got=%h exp=54", mem_wdata); end
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky got=%h exp=1", err); end
      bus_out = IDLE;
      step();
   endtask

   task automatic test_reset_mid_write();
      bus_out = 8'hF7;
      step();
      bus_out = IDLE;
      step();
      bus_out = 8'h09;
      step();
      rst = 1'b0;
      #1;
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL mid_rst_we got=%h exp=0", mem_we); end
      n_vec++; if (mem_waddr !== 7'h00 || mem_wdata !== 8'h00) begin n_err++; $display("FAIL mid_rst_wregs got=%h/%h exp=00/00", mem_waddr, mem_wdata); end
      n_vec++; if (err !== 1'b0 || choose !== 1'b0 || mem_raddr !== 7'h00) begin n_err++; $display("FAIL mid_rst_state got=%h/%h/%h exp=0/0/00", err, choose, mem_raddr); end
      bus_out = 8'h0A;
      step();
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL mid_rst_hold_we got=%h exp=0", mem_we); end
      bus_out = IDLE;
      #2 rst = 1'b1;
      step();
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL post_rst_we got=%h exp=0", mem_we); end
      n_vec++; if (choose !== 1'b1) begin n_err++; $display("FAIL post_rst_choose got=%h exp=1", choose); end
      bus_out = 8'hF7;
      step();
      bus_out = 8'h0C;
      step();
      n_vec++; if (mem_wdata !== 8'hC0) begin n_err++; $display("FAIL post_rst_tmp got=%h exp=C0", mem_wdata); end
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL post_rst_err got=%h exp=1", err); end
      bus_out = IDLE;
      step();
   endtask

   task automatic test_program();
      logic [7:0] vals [20];
      int         n_wr;
      for (int i = 0; i < 15; i++) vals[i] = 8'(15 - i);
      vals[15] = 8'h22; vals[16] = 8'hEE; vals[17] = 8'h88;
      vals[18] = 8'h66; vals[19] = 8'hAA;
      n_wr = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         bus_out = 8'hF7;
         step();
         n_wr += int'(mem_we);
         bus_out = IDLE;
         step();
         n_wr += int'(mem_we);
         bus_out = {4'h0, vals[i][3:0]};
         step();
         n_wr += int'(mem_we);
         bus_out = {4'h0, vals[i][7:4]};
         step();
         n_wr += int'(mem_we);
         n_vec++; if (mem_we !== 1'b1 || mem_waddr !== 7'h77 || mem_wdata !== vals[i]) begin n_err++; $display("FAIL prog_wr%0d got=%h/%h/%h exp=1/77/%h", i, mem_we, mem_waddr, mem_wdata, vals[i]); end
      end
      bus_out = IDLE;
      step();
      n_wr += int'(mem_we);
      n_vec++; if (n_wr != 20) begin n_err++; $display("FAIL prog_count got=%0d exp=20", n_wr); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL prog_err got=%h exp=0", err); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      bus_out = IDLE;
      mem_rdata = 8'h00;
      test_reset();
      test_strobe_phase();
      test_read_mux();
      test_write();
      test_partial_write();
      test_reset_mid_write();
      test_program();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
